// File: rtl/pipe_sel_mux.sv
// Registered N:1 select stage with valid/ready handshake, 2-entry skid buffer and flush.
// Optional build macro SEL_CHECK_EN: out-of-range selects store zero and pulse sel_err.
module pipe_sel_mux #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  localparam int SEL_W = $clog2(NUM_IN)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    flush,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  logic             skid_valid;
  logic [WIDTH-1:0] skid_data;
  logic [WIDTH-1:0] mux_data;
  logic             accept;
  logic             main_load;

  // in_ready depends only on registered state, so out_ready never reaches it combinationally
  assign in_ready  = ~skid_valid;
  assign accept    = in_valid & in_ready & ~flush;
  assign main_load = ~out_valid | out_ready;

  // Unmatched (out-of-range) selects fall through to the default word
  always_comb begin
`ifdef SEL_CHECK_EN
    mux_data = '0;
`else
    mux_data = in_data[WIDTH-1:0];
`endif
    for (int k = 0; k < NUM_IN; k++) begin
      if (sel == SEL_W'(k)) mux_data = in_data[k*WIDTH +: WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else if (flush) begin
      // out_data intentionally keeps its last value
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load) begin
        if (skid_valid) begin
          out_data   <= skid_data;
          out_valid  <= 1'b1;
          skid_valid <= 1'b0;
        end else if (accept) begin
          out_data  <= mux_data;
          out_valid <= 1'b1;
        end else begin
          out_valid <= 1'b0;
        end
      end else if (accept) begin
        skid_data  <= mux_data;
        skid_valid <= 1'b1;
      end
    end
  end

`ifdef SEL_CHECK_EN
  localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);

  logic sel_bad;
  logic sel_err_q;

  assign sel_bad = ({1'b0, sel} >= NUM_IN_W);
  assign sel_err = sel_err_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err_q <= 1'b0;
    else        sel_err_q <= accept & sel_bad;
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_sel_mux.sv
// Directed bench for pipe_sel_mux at WIDTH=5, NUM_IN=3; expectations follow SEL_CHECK_EN.
module tb_pipe_sel_mux;
  localparam int WIDTH  = 5;
  localparam int NUM_IN = 3;

  logic                    clk;
  logic                    rst_n;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [1:0]              sel;
  logic                    in_valid;
  logic                    in_ready;
  logic                    flush;
  logic [WIDTH-1:0]        out_data;
  logic                    out_valid;
  logic                    out_ready;
  logic                    sel_err;

  int checks;
  int errors;

  pipe_sel_mux #(.WIDTH(WIDTH), .NUM_IN(NUM_IN)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .sel(sel),
    .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [14:0] pack(input logic [4:0] c0, input logic [4:0] c1,
                                       input logic [4:0] c2);
    return {c2, c1, c0};
  endfunction

  // A select that is X/Z on an accepted beat is a stimulus error
  always @(posedge clk)
    if (rst_n === 1'b1 && in_valid === 1'b1 && in_ready === 1'b1 && flush === 1'b0)
      check("sel_known", 32'($isunknown(sel)), 32'd0);

  logic [4:0] exp_stream [8];

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    sel = 2'd0; in_data = '0;
    #12;
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_out_data", 32'(out_data), 0);
    check("rst_sel_err", 32'(sel_err), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    rst_n = 1'b1;
    step();

    // 1: single beat, ch1
    in_data = pack(5'b00011, 5'b10101, 5'b01100); sel = 2'd1;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    check("t1_valid", 32'(out_valid), 1);
    check("t1_data", 32'(out_data), 32'b10101);
    check("t1_sel_err", 32'(sel_err), 0);
    step();
    check("t1_drain", 32'(out_valid), 0);

    // 2: backpressure fills main and skid, third beat waits
    out_ready = 1'b0; sel = 2'd0;
    in_data = pack(5'b01010, 5'd0, 5'd0); in_valid = 1'b1;
    step();
    check("t2_ready_a", 32'(in_ready), 1);
    in_data = pack(5'b00101, 5'd0, 5'd0);
    step();
    check("t2_full", 32'(in_ready), 0);
    in_data = pack(5'b11111, 5'd0, 5'd0);
    step();
    check("t2_hold_data", 32'(out_data), 32'b01010);
    check("t2_hold_ready", 32'(in_ready), 0);
    out_ready = 1'b1;
    step();
    check("t2_second", 32'(out_data), 32'b00101);
    check("t2_ready_back", 32'(in_ready), 1);
    step();
    in_valid = 1'b0;
    check("t2_third", 32'(out_data), 32'b11111);
    check("t2_third_valid", 32'(out_valid), 1);
    step();
    check("t2_empty", 32'(out_valid), 0);

    // 3: streaming, alternating ch0 / ch2
    exp_stream = '{5'd0, 5'd17, 5'd2, 5'd19, 5'd4, 5'd21, 5'd6, 5'd23};
    for (int i = 0; i < 8; i++) begin
      in_data = pack(5'(i), 5'd31, 5'(i + 16));
      sel = (i % 2 == 1) ? 2'd2 : 2'd0;
      in_valid = 1'b1;
      step();
      check($sformatf("t3_valid_%0d", i), 32'(out_valid), 1);
      check($sformatf("t3_data_%0d", i), 32'(out_data), 32'(exp_stream[i]));
      check($sformatf("t3_ready_%0d", i), 32'(in_ready), 1);
    end
    in_valid = 1'b0;
    step();
    check("t3_end", 32'(out_valid), 0);

    // 4: flush with main+skid full, then flush of an otherwise-accepted beat
    out_ready = 1'b0; sel = 2'd0;
    in_data = pack(5'b00001, 5'd0, 5'd0); in_valid = 1'b1;
    step();
    in_data = pack(5'b00010, 5'd0, 5'd0);
    step();
    check("t4_full", 32'(in_ready), 0);
    in_data = pack(5'b00111, 5'd0, 5'd0); flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_valid", 32'(out_valid), 0);
    check("t4_ready", 32'(in_ready), 1);
    check("t4_data_kept", 32'(out_data), 32'b00001);
    out_ready = 1'b1;
    step();
    check("t4_no_ghost", 32'(out_valid), 0);
    in_data = pack(5'b01001, 5'd0, 5'd0); in_valid = 1'b1; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    check("t4_suppressed", 32'(out_valid), 0);
    step();
    check("t4_suppressed2", 32'(out_valid), 0);

    // 5: out-of-range select
    in_data = pack(5'b01110, 5'b10001, 5'b11011); sel = 2'd3; in_valid = 1'b1;
    step();
    in_valid = 1'b0; sel = 2'd0;
    check("t5_valid", 32'(out_valid), 1);
`ifdef SEL_CHECK_EN
    check("t5_data", 32'(out_data), 0);
    check("t5_sel_err", 32'(sel_err), 1);
`else
    check("t5_data", 32'(out_data), 32'b01110);
    check("t5_sel_err", 32'(sel_err), 0);
`endif
    step();
    check("t5_err_pulse", 32'(sel_err), 0);
    check("t5_drain", 32'(out_valid), 0);

    // 6: asynchronous reset between edges with skid full
    out_ready = 1'b0;
    in_data = pack(5'b10011, 5'd0, 5'd0); in_valid = 1'b1;
    step();
    in_data = pack(5'b01101, 5'd0, 5'd0);
    step();
    in_valid = 1'b0;
    check("t6_full", 32'(in_ready), 0);
    #2 rst_n = 1'b0;
    #1;
    check("t6_valid", 32'(out_valid), 0);
    check("t6_data", 32'(out_data), 0);
    check("t6_ready", 32'(in_ready), 1);
    #3 rst_n = 1'b1;
    out_ready = 1'b1;
    step();
    check("t6_after", 32'(out_valid), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
